// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: shared definitions for the instruction fetch stage.
//   - RV32 opcode constants used for next-PC prediction
//   - J-type / B-type immediate extraction (sign-extended to 32 bits)
//   - 2-bit saturating branch counter states
//   - fetch FSM state encoding
package inst_fetcher_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_WAIT  = 1'b1
  } state_e;

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetcher_branch_predictor.sv
// branch_predictor: table of 2-bit saturating counters (BHT).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (counters -> weakly not-taken)
//   lookup_idx     index of the branch being fetched
//   lookup_taken   MSB of the indexed counter (predict taken)
//   upd_en         resolved-branch update strobe
//   upd_idx        index of the resolved branch
//   upd_taken      actual outcome (+1 when taken, -1 otherwise, saturating)
// A lookup and an update to the same index in one cycle sees the old counter.
module branch_predictor
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned BHT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_WIDTH-1:0] lookup_idx,
  output logic                 lookup_taken,
  input  logic                 upd_en,
  input  logic [BHT_WIDTH-1:0] upd_idx,
  input  logic                 upd_taken
);

  localparam int unsigned ENTRIES = 1 << BHT_WIDTH;

  cnt_e bht_q [ENTRIES];
  cnt_e bht_d [ENTRIES];

  always_comb begin
    bht_d = bht_q;
    if (upd_en) begin
      case (bht_q[upd_idx])
        CNT_SNT: bht_d[upd_idx] = upd_taken ? CNT_WNT : CNT_SNT;
        CNT_WNT: bht_d[upd_idx] = upd_taken ? CNT_WT  : CNT_SNT;
        CNT_WT:  bht_d[upd_idx] = upd_taken ? CNT_ST  : CNT_WNT;
        default: bht_d[upd_idx] = upd_taken ? CNT_ST  : CNT_WT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_WNT;
    end else begin
      bht_q <= bht_d;
    end
  end

  assign lookup_taken = bht_q[lookup_idx][1];

endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch stage.
// Holds the fetch PC, issues one ICache request at a time (FETCH -> WAIT),
// predicts the next PC (JAL taken, conditional branches via optional BHT)
// and buffers fetched instructions in a 2**IQ_WIDTH entry queue.
// Ports:
//   Sys_clk, Sys_rst_n      clock, asynchronous active-low reset
//   Sys_rdy                 global enable (flush still acts when low)
//   IFIC_en/IFIC_addr       request to ICache, held until ICIF_en
//   ICIF_en/ICIF_data       ICache response pulse and instruction
//   RoBIF_pre_judge/_next_pc  low = misprediction flush, redirect target
//   RoBIF_br_en/_br_pc/_br_taken  resolved branch for BHT training
//   IFDC_en/_inst/_pc/_pred_taken  queue head to decoder
//   DCIF_pop                decoder consumes head
// Build option: define IF_BHT_EN to instantiate the branch predictor;
// otherwise conditional branches are predicted not-taken.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IQ_WIDTH   = 2,
  parameter int unsigned BHT_WIDTH  = 6
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst_n,
  input  logic                  Sys_rdy,
  output logic                  IFIC_en,
  output logic [ADDR_WIDTH-1:0] IFIC_addr,
  input  logic                  ICIF_en,
  input  logic [31:0]           ICIF_data,
  input  logic                  RoBIF_pre_judge,
  input  logic [ADDR_WIDTH-1:0] RoBIF_next_pc,
  input  logic                  RoBIF_br_en,
  input  logic [ADDR_WIDTH-1:0] RoBIF_br_pc,
  input  logic                  RoBIF_br_taken,
  output logic                  IFDC_en,
  output logic [31:0]           IFDC_inst,
  output logic [ADDR_WIDTH-1:0] IFDC_pc,
  output logic                  IFDC_pred_taken,
  input  logic                  DCIF_pop
);

  localparam int unsigned DEPTH = 1 << IQ_WIDTH;
  localparam logic [IQ_WIDTH:0] FULL = (IQ_WIDTH+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ific_en_q, ific_en_d;
  logic [ADDR_WIDTH-1:0] ific_addr_q, ific_addr_d;
  logic [IQ_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [IQ_WIDTH:0]     count_q, count_d;
  logic [31:0]           q_inst_q [DEPTH];
  logic [31:0]           q_inst_d [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_d   [DEPTH];
  logic                  q_pred_q [DEPTH];
  logic                  q_pred_d [DEPTH];

  logic                  flush, push, pop, bht_taken, pred_taken;
  logic [ADDR_WIDTH-1:0] next_pc;

  assign flush = !RoBIF_pre_judge;
  assign push  = !flush && Sys_rdy && (state_q == ST_WAIT) && ICIF_en;
  assign pop   = !flush && Sys_rdy && DCIF_pop && (count_q != '0);

`ifdef IF_BHT_EN
  // Training follows the global freeze, except a flush cycle still trains.
  branch_predictor #(.BHT_WIDTH(BHT_WIDTH)) u_bp (
    .clk          (Sys_clk),
    .rst_n        (Sys_rst_n),
    .lookup_idx   (pc_q[BHT_WIDTH+1:2]),
    .lookup_taken (bht_taken),
    .upd_en       (RoBIF_br_en && (Sys_rdy || flush)),
    .upd_idx      (RoBIF_br_pc[BHT_WIDTH+1:2]),
    .upd_taken    (RoBIF_br_taken)
  );
  logic unused_br_pc;
  assign unused_br_pc = ^RoBIF_br_pc;
`else
  localparam int unsigned bht_width_unused = BHT_WIDTH;
  logic unused_br;
  assign unused_br = ^{RoBIF_br_en, RoBIF_br_pc, RoBIF_br_taken};
  assign bht_taken = 1'b0;
`endif

  // Next PC for the instruction currently being returned (pc_q is its PC).
  always_comb begin
    pred_taken = 1'b0;
    next_pc    = pc_q + ADDR_WIDTH'(32'd4);
    case (ICIF_data[6:0])
      OPC_JAL: begin
        pred_taken = 1'b1;
        next_pc    = pc_q + ADDR_WIDTH'(imm_j(ICIF_data));
      end
      OPC_BRANCH: begin
        if (bht_taken) begin
          pred_taken = 1'b1;
          next_pc    = pc_q + ADDR_WIDTH'(imm_b(ICIF_data));
        end
      end
      OPC_JALR: pred_taken = 1'b0;
      default:  pred_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ific_en_d   = ific_en_q;
    ific_addr_d = ific_addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    q_inst_d    = q_inst_q;
    q_pc_d      = q_pc_q;
    q_pred_d    = q_pred_q;
    if (flush) begin
      pc_d      = RoBIF_next_pc;
      ific_en_d = 1'b0;
      state_d   = ST_FETCH;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
    end else if (Sys_rdy) begin
      case (state_q)
        ST_FETCH: begin
          if (count_q != FULL) begin
            ific_en_d   = 1'b1;
            ific_addr_d = pc_q;
            state_d     = ST_WAIT;
          end
        end
        default: begin
          if (ICIF_en) begin
            ific_en_d = 1'b0;
            pc_d      = next_pc;
            state_d   = ST_FETCH;
          end
        end
      endcase
      if (push) begin
        q_inst_d[tail_q] = ICIF_data;
        q_pc_d[tail_q]   = pc_q;
        q_pred_d[tail_q] = pred_taken;
        tail_d           = tail_q + IQ_WIDTH'(1);
      end
      if (pop) head_d = head_q + IQ_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (IQ_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (IQ_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ific_en_q   <= 1'b0;
      ific_addr_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
        q_pred_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ific_en_q   <= ific_en_d;
      ific_addr_q <= ific_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      q_inst_q    <= q_inst_d;
      q_pc_q      <= q_pc_d;
      q_pred_q    <= q_pred_d;
    end
  end

  assign IFIC_en         = ific_en_q;
  assign IFIC_addr       = ific_addr_q;
  assign IFDC_en         = (count_q != '0);
  assign IFDC_inst       = IFDC_en ? q_inst_q[head_q] : '0;
  assign IFDC_pc         = IFDC_en ? q_pc_q[head_q]   : '0;
  assign IFDC_pred_taken = IFDC_en && q_pred_q[head_q];

endmodule

// File: tb/tb_inst_fetcher.sv
module tb_inst_fetcher;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JAL20  = 32'h0200_00EF;  // jal x1, +0x20
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;  // beq x0, x0, -8

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Sys_rdy;
  logic        IFIC_en;
  logic [31:0] IFIC_addr;
  logic        ICIF_en;
  logic [31:0] ICIF_data;
  logic        RoBIF_pre_judge;
  logic [31:0] RoBIF_next_pc;
  logic        RoBIF_br_en;
  logic [31:0] RoBIF_br_pc;
  logic        RoBIF_br_taken;
  logic        IFDC_en;
  logic [31:0] IFDC_inst;
  logic [31:0] IFDC_pc;
  logic        IFDC_pred_taken;
  logic        DCIF_pop;

  int   checks = 0;
  int   errors = 0;
  logic auto_cache;
  logic req_seen;

  inst_fetcher #(.ADDR_WIDTH(32), .IQ_WIDTH(2), .BHT_WIDTH(6)) dut (
    .Sys_clk         (clk),
    .Sys_rst_n       (rst_n),
    .Sys_rdy         (Sys_rdy),
    .IFIC_en         (IFIC_en),
    .IFIC_addr       (IFIC_addr),
    .ICIF_en         (ICIF_en),
    .ICIF_data       (ICIF_data),
    .RoBIF_pre_judge (RoBIF_pre_judge),
    .RoBIF_next_pc   (RoBIF_next_pc),
    .RoBIF_br_en     (RoBIF_br_en),
    .RoBIF_br_pc     (RoBIF_br_pc),
    .RoBIF_br_taken  (RoBIF_br_taken),
    .IFDC_en         (IFDC_en),
    .IFDC_inst       (IFDC_inst),
    .IFDC_pc         (IFDC_pc),
    .IFDC_pred_taken (IFDC_pred_taken),
    .DCIF_pop        (DCIF_pop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    case (addr)
      32'h10:  return JAL20;
      32'h40:  return BEQ_M8;
      default: return NOP;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the cache answers one cycle after it sees a held request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_cache) begin
      ICIF_en   = IFIC_en && req_seen && !ICIF_en;
      ICIF_data = imem(IFIC_addr);
      req_seen  = IFIC_en;
    end
  endtask

  task automatic wait_fetch(input string tag, input logic [31:0] addr, input logic pop_on_resp);
    int n = 0;
    while (!IFIC_en && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(IFIC_en), 32'd1);
    chk({tag, "_addr"}, IFIC_addr, addr);
    tick();
    DCIF_pop = pop_on_resp;
    tick();
    DCIF_pop = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; Sys_rdy = 1'b1; ICIF_en = 1'b0; ICIF_data = '0;
    RoBIF_pre_judge = 1'b1; RoBIF_next_pc = '0;
    RoBIF_br_en = 1'b0; RoBIF_br_pc = '0; RoBIF_br_taken = 1'b0;
    DCIF_pop = 1'b0; auto_cache = 1'b1; req_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ific_en", 32'(IFIC_en), 32'd0);
    chk("rst_ific_addr", IFIC_addr, 32'h0);
    chk("rst_ifdc_en", 32'(IFDC_en), 32'd0);
    chk("rst_ifdc_inst", IFDC_inst, 32'h0);
    chk("rst_ifdc_pc", IFDC_pc, 32'h0);
    chk("rst_ifdc_pred", 32'(IFDC_pred_taken), 32'd0);
    rst_n = 1'b1;

    // First fetch: request one edge after reset release, data visible after response.
    tick();
    chk("first_req_en", 32'(IFIC_en), 32'd1);
    chk("first_req_addr", IFIC_addr, 32'h0);
    tick();
    chk("first_resp_empty", 32'(IFDC_en), 32'd0);
    tick();
    chk("first_q_en", 32'(IFDC_en), 32'd1);
    chk("first_q_pc", IFDC_pc, 32'h0);
    chk("first_q_inst", IFDC_inst, NOP);
    chk("first_recovery", 32'(IFIC_en), 32'd0);

    // Fill the queue without popping.
    wait_fetch("f4", 32'h4, 1'b0);
    wait_fetch("f8", 32'h8, 1'b0);
    wait_fetch("f12", 32'hC, 1'b0);
    repeat (5) tick();
    chk("full_hold", 32'(IFIC_en), 32'd0);
    chk("full_head", IFDC_pc, 32'h0);

    // One pop frees a slot; then push+pop together wraps the tail.
    DCIF_pop = 1'b1;
    tick();
    DCIF_pop = 1'b0;
    chk("pop_head", IFDC_pc, 32'h4);
    wait_fetch("f16", 32'h10, 1'b1);
    chk("pushpop_head", IFDC_pc, 32'h8);
    chk("pushpop_en", 32'(IFDC_en), 32'd1);

    // JAL at 0x10 -> 0x30, predicted taken.
    wait_fetch("jal_tgt", 32'h30, 1'b0);
    DCIF_pop = 1'b1;
    tick();
    tick();
    DCIF_pop = 1'b0;
    chk("jal_pc", IFDC_pc, 32'h10);
    chk("jal_inst", IFDC_inst, JAL20);
    chk("jal_pred", 32'(IFDC_pred_taken), 32'd1);

    // Flush in WAIT while the response arrives.
    n = 0;
    while (!ICIF_en && n < 20) begin
      tick();
      n++;
    end
    chk("pre_flush_resp", 32'(ICIF_en), 32'd1);
    RoBIF_pre_judge = 1'b0;
    RoBIF_next_pc = 32'h100;
    tick();
    RoBIF_pre_judge = 1'b1;
    chk("flush_empty", 32'(IFDC_en), 32'd0);
    chk("flush_ific", 32'(IFIC_en), 32'd0);
    tick();
    chk("flush_req", 32'(IFIC_en), 32'd1);
    chk("flush_addr", IFIC_addr, 32'h100);
    chk("flush_drop", 32'(IFDC_en), 32'd0);

    // Stall 5 cycles mid-WAIT with response pulses that must not be taken.
    auto_cache = 1'b0;
    ICIF_en = 1'b0;
    Sys_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ICIF_en = (i >= 1 && i <= 3);
      ICIF_data = NOP;
      tick();
      chk("stall_en", 32'(IFIC_en), 32'd1);
      chk("stall_addr", IFIC_addr, 32'h100);
      chk("stall_q", 32'(IFDC_en), 32'd0);
    end
    ICIF_en = 1'b0;
    Sys_rdy = 1'b1;
    tick();
    chk("post_stall_en", 32'(IFIC_en), 32'd1);
    chk("post_stall_q", 32'(IFDC_en), 32'd0);
    ICIF_en = 1'b1;
    ICIF_data = imem(32'h100);
    tick();
    ICIF_en = 1'b0;
    chk("resume_pc", IFDC_pc, 32'h100);
    chk("resume_ific", 32'(IFIC_en), 32'd0);
    auto_cache = 1'b1;
    req_seen = 1'b0;

    // Train branch at 0x40 taken twice, then redirect to it.
    RoBIF_br_en = 1'b1;
    RoBIF_br_pc = 32'h40;
    RoBIF_br_taken = 1'b1;
    tick();
    tick();
    RoBIF_br_en = 1'b0;
    RoBIF_pre_judge = 1'b0;
    RoBIF_next_pc = 32'h40;
    tick();
    RoBIF_pre_judge = 1'b1;
    DCIF_pop = 1'b1;
    tick();
    DCIF_pop = 1'b0;
    chk("pop_on_empty", 32'(IFDC_en), 32'd0);
    wait_fetch("br", 32'h40, 1'b0);
    chk("br_head_pc", IFDC_pc, 32'h40);
    chk("br_head_inst", IFDC_inst, BEQ_M8);
`ifdef IF_BHT_EN
    chk("br_pred", 32'(IFDC_pred_taken), 32'd1);
`else
    chk("br_pred", 32'(IFDC_pred_taken), 32'd0);
`endif
    DCIF_pop = 1'b1;
    tick();
    DCIF_pop = 1'b0;
    chk("br_pop_empty", 32'(IFDC_en), 32'd0);
    chk("br_next_en", 32'(IFIC_en), 32'd1);
`ifdef IF_BHT_EN
    chk("br_next_addr", IFIC_addr, 32'h38);
`else
    chk("br_next_addr", IFIC_addr, 32'h44);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
